// File: rtl/axis_dense_layer_pkg.sv
// Shared definitions for the AXI-Stream dense (fully connected) layer.
//   - FSM state encoding
//   - settings-bus register offsets, relative to SR_BASE
//   - acc_w(): accumulator width that cannot overflow over one frame
package axis_dense_layer_pkg;

  localparam logic [1:0] ST_ACCUM = 2'd0;
  localparam logic [1:0] ST_EMIT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int SR_COEF_IDX  = 0;
  localparam int SR_COEF_DATA = 1;
  localparam int SR_CTRL      = 2;

  // Each product needs 2*data_w bits. Summing n_in of them needs clog2(n_in)
  // more bits. The bias, pre-shifted by FRAC, needs one extra bit on top.
  function automatic int acc_w(input int data_w, input int n_in);
    return 2 * data_w + $clog2(n_in) + 1;
  endfunction

endpackage

// File: rtl/dense_mac_lane.sv
// One output neuron: a multiply-accumulate register, then saturate and ReLU.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   mac_en       accumulate x*w this cycle
//   first        first sample of the frame: start from bias<<FRAC, not acc
//   relu         clamp negative results to zero
//   x, w, bias   signed sample, weight and bias (FRAC fractional bits)
//   y            sat(acc >>> FRAC), after the optional ReLU
module dense_mac_lane #(
  parameter int DATA_W = 16,
  parameter int FRAC   = 8,
  parameter int ACC_W  = 35
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mac_en,
  input  logic                     first,
  input  logic                     relu,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] w,
  input  logic signed [DATA_W-1:0] bias,
  output logic        [DATA_W-1:0] y
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [2*DATA_W-1:0] x_ext, w_ext, prod;
  logic signed [ACC_W-1:0]    prod_ext, bias_ext, base, acc, shifted;

  // Sign-extend both operands first, so the full product is kept.
  assign x_ext    = {{DATA_W{x[DATA_W-1]}}, x};
  assign w_ext    = {{DATA_W{w[DATA_W-1]}}, w};
  assign prod     = x_ext * w_ext;
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign bias_ext = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias} <<< FRAC;

  // The bias is folded into the first product of the frame. A frame that
  // is discarded therefore never leaves stale state behind.
  assign base = first ? bias_ext : acc;

  // NOTE: registers take non-blocking assignments, so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (mac_en) begin
      acc <= base + prod_ext;
    end
  end

  assign shifted = acc >>> FRAC;

  // NOTE: y gets a default before any branch, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    y = shifted[DATA_W-1:0];
    if (shifted > SAT_MAX) begin
      y = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      y = {1'b1, {(DATA_W-1){1'b0}}};
    end
    if (relu && y[DATA_W-1]) begin
      y = '0;
    end
  end

endmodule

// File: rtl/axis_dense_layer.sv
// AXI-Stream dense layer: y[j] = sat((b[j]<<FRAC + sum_i x_i*w[i][j]) >>> FRAC).
// Each frame has N_IN input samples and produces N_OUT output samples.
// Ports:
//   ce_clk, ce_rst               clock and synchronous active-high reset
//   set_stb/set_addr/set_data    settings bus: coefficient index, coefficient
//                                write (auto-increment), control register
//   s_axis_*                     input sample stream
//   m_axis_*                     output sample stream; combinational pass-through
//                                when bypassed
//   err_short, err_long          sticky frame-length errors, cleared by ctrl bit2
//   frame_cnt                    emitted-frame counter (wraps)
module axis_dense_layer
  import axis_dense_layer_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int FRAC    = 8,
  parameter int N_IN    = 8,
  parameter int N_OUT   = 4,
  parameter int SR_BASE = 128
) (
  input  logic              ce_clk,
  input  logic              ce_rst,
  input  logic              set_stb,
  input  logic [7:0]        set_addr,
  input  logic [31:0]       set_data,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              err_short,
  output logic              err_long,
  output logic [31:0]       frame_cnt
);

  localparam int ACC_W    = acc_w(DATA_W, N_IN);
  localparam int NUM_COEF = (N_IN + 1) * N_OUT;
  localparam int IDX_W    = $clog2(NUM_COEF);
  localparam int CNT_W    = $clog2(N_IN);
  localparam int OI_W     = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic [7:0] ADDR_IDX  = 8'(SR_BASE + SR_COEF_IDX);
  localparam logic [7:0] ADDR_COEF = 8'(SR_BASE + SR_COEF_DATA);
  localparam logic [7:0] ADDR_CTRL = 8'(SR_BASE + SR_CTRL);

  logic [DATA_W-1:0] coef [NUM_COEF];
  logic [31:0]       coef_idx;
  logic              ctrl_en, ctrl_relu;
  logic              en_q, relu_q;
  logic [1:0]        state;
  logic [CNT_W-1:0]  count;
  logic [OI_W-1:0]   out_idx;
  logic              long_q;

  logic wr_idx, wr_coef, wr_ctrl, clr_err;
  logic s_fire, m_fire, first, last_in, out_last, mac_en;
  logic set_short, set_long;
  logic [DATA_W-1:0] lane_y [N_OUT];

  assign wr_idx  = set_stb && (set_addr == ADDR_IDX);
  assign wr_coef = set_stb && (set_addr == ADDR_COEF);
  assign wr_ctrl = set_stb && (set_addr == ADDR_CTRL);
  assign clr_err = wr_ctrl && set_data[2];

  // NOTE: the coefficient store is built from flops rather than RAM, so it
  // can be cleared by reset like any other register.
  always_ff @(posedge ce_clk) begin
    if (ce_rst) begin
      coef_idx  <= '0;
      ctrl_en   <= 1'b0;
      ctrl_relu <= 1'b0;
      for (int k = 0; k < NUM_COEF; k++) coef[k] <= '0;
    end else begin
      if (wr_idx) begin
        coef_idx <= set_data;
      end else if (wr_coef) begin
        if (coef_idx < 32'(NUM_COEF)) coef[coef_idx[IDX_W-1:0]] <= set_data[DATA_W-1:0];
        coef_idx <= coef_idx + 32'd1;
      end
      if (wr_ctrl) begin
        ctrl_en   <= set_data[0];
        ctrl_relu <= set_data[1];
      end
    end
  end

  assign s_fire    = s_axis_tvalid && s_axis_tready;
  assign m_fire    = m_axis_tvalid && m_axis_tready;
  assign first     = (state == ST_ACCUM) && (count == '0);
  assign last_in   = (count == CNT_W'(N_IN - 1));
  assign out_last  = (out_idx == OI_W'(N_OUT - 1));
  assign mac_en    = en_q && (state == ST_ACCUM) && s_fire;
  assign set_short = mac_en && s_axis_tlast && !last_in;
  assign set_long  = mac_en && !s_axis_tlast && last_in;

  always_ff @(posedge ce_clk) begin
    if (ce_rst) begin
      state     <= ST_ACCUM;
      count     <= '0;
      out_idx   <= '0;
      long_q    <= 1'b0;
      en_q      <= 1'b0;
      relu_q    <= 1'b0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      // Mode changes only take effect between frames.
      if (first) begin
        en_q   <= ctrl_en;
        relu_q <= ctrl_relu;
      end
      // A clear has priority over a simultaneous error.
      err_short <= !clr_err && (err_short || set_short);
      err_long  <= !clr_err && (err_long || set_long);
      if (en_q) begin
        case (state)
          ST_ACCUM: if (s_fire) begin
            if (last_in) begin
              count  <= '0;
              long_q <= !s_axis_tlast;
              state  <= ST_EMIT;
            end else if (s_axis_tlast) begin
              count <= '0;
            end else begin
              count <= count + 1'b1;
            end
          end
          ST_EMIT: if (m_fire) begin
            if (out_last) begin
              out_idx   <= '0;
              frame_cnt <= frame_cnt + 32'd1;
              state     <= long_q ? ST_DRAIN : ST_ACCUM;
            end else begin
              out_idx <= out_idx + 1'b1;
            end
          end
          ST_DRAIN: if (s_fire && s_axis_tlast) begin
            long_q <= 1'b0;
            state  <= ST_ACCUM;
          end
          default: state <= ST_ACCUM;
        endcase
      end
    end
  end

  // The accumulators stay frozen during EMIT, so tdata is stable under
  // backpressure without an extra output register.
  always_comb begin
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = lane_y[out_idx];
    m_axis_tlast  = out_last;
    if (!en_q) begin
      s_axis_tready = m_axis_tready;
      m_axis_tvalid = s_axis_tvalid;
      m_axis_tdata  = s_axis_tdata;
      m_axis_tlast  = s_axis_tlast;
    end else begin
      case (state)
        ST_ACCUM: s_axis_tready = 1'b1;
        ST_EMIT:  m_axis_tvalid = 1'b1;
        ST_DRAIN: s_axis_tready = 1'b1;
        default:  ;
      endcase
    end
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_lane
    dense_mac_lane #(
      .DATA_W(DATA_W),
      .FRAC  (FRAC),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk   (ce_clk),
      .rst   (ce_rst),
      .mac_en(mac_en),
      .first (first),
      .relu  (relu_q),
      .x     (s_axis_tdata),
      .w     (coef[IDX_W'(int'(count) * N_OUT + j)]),
      .bias  (coef[IDX_W'(N_IN * N_OUT + j)]),
      .y     (lane_y[j])
    );
  end

endmodule
